// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the
// default bit period used by both transmitter and receiver.
package uart_pkg;

  localparam int UART_WAIT_DIV = 25;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
// The reset value lets an idle-high line come out of reset idle.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART 8N1 receiver: mid-bit sampling with a clock-count timer,
// valid/ready byte output, framing and overrun pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int WAIT_DIV = UART_WAIT_DIV
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] rdata,
  output logic       rvalid,
  input  logic       rready,
  output logic       ferr,
  output logic       ovf
);

  localparam int CW = $clog2(WAIT_DIV);
  localparam logic [CW-1:0] HALF = CW'(WAIT_DIV / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(WAIT_DIV - 1);

  uart_rx_state_t state, state_n;

  logic          rxd_s, rxd_p;
  logic [CW-1:0] wait_cnt, wait_n;
  logic [2:0]    bit_cnt, bit_n;
  logic [7:0]    shift, shift_n;
  logic [7:0]    rdata_n;
  logic          rvalid_n, ferr_n, ovf_n;
  logic          deliver;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxd_s)
  );

  always_comb begin
    state_n  = state;
    wait_n   = wait_cnt;
    bit_n    = bit_cnt;
    shift_n  = shift;
    rdata_n  = rdata;
    rvalid_n = rvalid;
    ferr_n   = 1'b0;
    ovf_n    = 1'b0;
    deliver  = 1'b0;

    if (rvalid && rready)
      rvalid_n = 1'b0;

    unique case (state)
      IDLE: begin
        // Edge-triggered so a held-low line cannot restart frames.
        if (rxd_p && !rxd_s) begin
          state_n = START;
          wait_n  = '0;
        end
      end
      START: begin
        if (wait_cnt == HALF) begin
          wait_n = '0;
          if (!rxd_s) begin
            state_n = DATA;
            bit_n   = 3'd0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          wait_n = wait_cnt + CW'(1);
        end
      end
      DATA: begin
        if (wait_cnt == LAST) begin
          wait_n  = '0;
          shift_n = {rxd_s, shift[7:1]};
          if (bit_cnt == 3'd7)
            state_n = STOP;
          else
            bit_n = bit_cnt + 3'd1;
        end else begin
          wait_n = wait_cnt + CW'(1);
        end
      end
      STOP: begin
        if (wait_cnt == LAST) begin
          wait_n  = '0;
          state_n = IDLE;
          if (rxd_s)
            deliver = 1'b1;
          else
            ferr_n = 1'b1;
        end else begin
          wait_n = wait_cnt + CW'(1);
        end
      end
    endcase

    // A consume in the same cycle frees the slot for the new byte.
    if (deliver) begin
      if (rvalid && !rready) begin
        ovf_n = 1'b1;
      end else begin
        rdata_n  = shift;
        rvalid_n = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rxd_p    <= 1'b1;
      wait_cnt <= '0;
      bit_cnt  <= 3'd0;
      shift    <= 8'd0;
      rdata    <= 8'd0;
      rvalid   <= 1'b0;
      ferr     <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      state    <= state_n;
      rxd_p    <= rxd_s;
      wait_cnt <= wait_n;
      bit_cnt  <= bit_n;
      shift    <= shift_n;
      rdata    <= rdata_n;
      rvalid   <= rvalid_n;
      ferr     <= ferr_n;
      ovf      <= ovf_n;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with a 5-clock-per-bit line model.
// A negedge monitor counts rvalid rises and error pulses.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic [7:0] rdata;
  logic       rvalid;
  logic       rready;
  logic       ferr;
  logic       ovf;

  int vecs = 0;
  int errs = 0;

  int         n_rise = 0;
  int         n_ferr = 0;
  int         n_ovf  = 0;
  logic [7:0] cap    = 8'h00;
  logic       prev_rv = 1'b0;

  always #5 clk = ~clk;

  uart_rx #(.WAIT_DIV(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .rxd    (rxd),
    .rdata  (rdata),
    .rvalid (rvalid),
    .rready (rready),
    .ferr   (ferr),
    .ovf    (ovf)
  );

  always @(negedge clk) begin
    if (rvalid && !prev_rv) begin
      n_rise = n_rise + 1;
      cap    = rdata;
    end
    if (ferr) n_ferr = n_ferr + 1;
    if (ovf)  n_ovf  = n_ovf + 1;
    prev_rv = rvalid;
  end

  task automatic clr_mon();
    @(posedge clk);
    #1;
    n_rise = 0;
    n_ferr = 0;
    n_ovf  = 0;
    cap    = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    idle(5);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      idle(5);
    end
    rxd = stop;
    idle(5);
    rxd = 1'b1;
  endtask

  task automatic test_reset();
    rst    = 1'b1;
    rxd    = 1'b1;
    rready = 1'b0;
    idle(4);
    vecs++;
    if (rvalid !== 1'b0) begin
      errs++;
      $display("FAIL reset_rvalid got %b want 0", rvalid);
    end
    vecs++;
    if (rdata !== 8'h00) begin
      errs++;
      $display("FAIL reset_rdata got %h want 00", rdata);
    end
    vecs++;
    if ({ferr, ovf} !== 2'b00) begin
      errs++;
      $display("FAIL reset_flags got %b want 00", {ferr, ovf});
    end
    rst = 1'b0;
    idle(5);
  endtask

  task automatic test_single();
    rready = 1'b1;
    clr_mon();
    send_byte(8'hA5, 1'b1);
    idle(4);
    vecs++;
    if (n_rise !== 1) begin
      errs++;
      $display("FAIL a5_rises got %0d want 1", n_rise);
    end
    vecs++;
    if (cap !== 8'hA5) begin
      errs++;
      $display("FAIL a5_data got %h want a5", cap);
    end
    vecs++;
    if (rvalid !== 1'b0) begin
      errs++;
      $display("FAIL a5_consumed got %b want 0", rvalid);
    end
    vecs++;
    if (n_ferr !== 0 || n_ovf !== 0) begin
      errs++;
      $display("FAIL a5_flags got ferr=%0d ovf=%0d want 0 0",
               n_ferr, n_ovf);
    end
  endtask

  task automatic test_back_to_back();
    rready = 1'b0;
    clr_mon();
    send_byte(8'h3C, 1'b1);
    send_byte(8'hC3, 1'b1);
    idle(4);
    vecs++;
    if (rvalid !== 1'b1 || rdata !== 8'h3C) begin
      errs++;
      $display("FAIL b2b_hold got v=%b d=%h want v=1 d=3c",
               rvalid, rdata);
    end
    vecs++;
    if (n_ovf !== 1) begin
      errs++;
      $display("FAIL b2b_ovf got %0d want 1", n_ovf);
    end
    vecs++;
    if (n_rise !== 1) begin
      errs++;
      $display("FAIL b2b_rises got %0d want 1", n_rise);
    end
    rready = 1'b1;
    idle(1);
    vecs++;
    if (rvalid !== 1'b0) begin
      errs++;
      $display("FAIL b2b_clear got %b want 0", rvalid);
    end
    idle(3);
  endtask

  task automatic test_framing();
    rready = 1'b1;
    clr_mon();
    send_byte(8'h55, 1'b0);
    idle(10);
    vecs++;
    if (n_ferr !== 1) begin
      errs++;
      $display("FAIL ferr_count got %0d want 1", n_ferr);
    end
    vecs++;
    if (n_rise !== 0) begin
      errs++;
      $display("FAIL ferr_dropped got %0d rises want 0", n_rise);
    end
    clr_mon();
    send_byte(8'h0F, 1'b1);
    idle(4);
    vecs++;
    if (n_rise !== 1 || cap !== 8'h0F) begin
      errs++;
      $display("FAIL after_ferr got %0d rises d=%h want 1 0f",
               n_rise, cap);
    end
    vecs++;
    if (n_ferr !== 0) begin
      errs++;
      $display("FAIL after_ferr_flag got %0d want 0", n_ferr);
    end
  endtask

  task automatic test_glitch();
    clr_mon();
    rxd = 1'b0;
    idle(1);
    rxd = 1'b1;
    idle(20);
    vecs++;
    if (n_rise !== 0 || n_ferr !== 0) begin
      errs++;
      $display("FAIL glitch got rises=%0d ferr=%0d want 0 0",
               n_rise, n_ferr);
    end
  endtask

  task automatic test_rst_midframe();
    clr_mon();
    rxd = 1'b0;
    idle(5);
    for (int i = 0; i < 4; i++) begin
      rxd = 1'b1;
      idle(5);
    end
    idle(2);
    rst = 1'b1;
    idle(2);
    vecs++;
    if (rvalid !== 1'b0 || rdata !== 8'h00) begin
      errs++;
      $display("FAIL rst_mid_out got v=%b d=%h want 0 00",
               rvalid, rdata);
    end
    vecs++;
    if ({ferr, ovf} !== 2'b00) begin
      errs++;
      $display("FAIL rst_mid_flags got %b want 00", {ferr, ovf});
    end
    rxd = 1'b1;
    rst = 1'b0;
    idle(15);
    clr_mon();
    send_byte(8'h81, 1'b1);
    idle(4);
    vecs++;
    if (n_rise !== 1 || cap !== 8'h81) begin
      errs++;
      $display("FAIL rst_next got %0d rises d=%h want 1 81",
               n_rise, cap);
    end
    vecs++;
    if (n_ferr !== 0 || n_ovf !== 0) begin
      errs++;
      $display("FAIL rst_next_flags got ferr=%0d ovf=%0d want 0 0",
               n_ferr, n_ovf);
    end
  endtask

  task automatic test_break();
    clr_mon();
    rxd = 1'b0;
    idle(100);
    vecs++;
    if (n_ferr !== 1) begin
      errs++;
      $display("FAIL break_ferr got %0d want 1", n_ferr);
    end
    vecs++;
    if (n_rise !== 0) begin
      errs++;
      $display("FAIL break_rises got %0d want 0", n_rise);
    end
    rxd = 1'b1;
    idle(10);
    clr_mon();
    send_byte(8'h5A, 1'b1);
    idle(4);
    vecs++;
    if (n_rise !== 1 || cap !== 8'h5A) begin
      errs++;
      $display("FAIL break_recover got %0d rises d=%h want 1 5a",
               n_rise, cap);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_framing();
    test_glitch();
    test_rst_midframe();
    test_break();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
